// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional address range checking is enabled with IFU_RANGE_CHECK_EN.
package ifu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } fifo_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Instruction buffer: synchronous FIFO with flush, occupancy count and
// a head entry that reads as zero while empty.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fifo_entry_t              push_entry,
    input  logic                     pop,
    output fifo_entry_t              head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);

    fifo_entry_t    mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && ((count != (PW+1)'(DEPTH)) || do_pop);
    assign head    = valid ? mem_q[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && rst_n && !flush) mem_q[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Fetch stage driving SRAM read port 1 and feeding decode through ifu_fifo.
// Define IFU_RANGE_CHECK_EN to fault misaligned/out-of-range fetch PCs.
module imem_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [31:0]           instr_pc,
    output logic                  fetch_fault
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e    state_q;
    ifu_state_e    state_d;
    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW-1:0] occ_after_pop;
    logic          pop;
    logic          push;
    logic          req_ok;
    logic          issue;
    logic          fault_now;
    logic          inflight_fault;
    fifo_entry_t   push_entry;
    fifo_entry_t   head_entry;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en)  state_d = RUN;
            RUN:     if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Credit counts the slot the in-flight word will occupy after this pop.
    assign pop           = instr_valid && instr_ready && !redirect_valid;
    assign occ_after_pop = count - CW'(pop);
    assign req_ok        = (state_q == RUN) && !redirect_valid &&
                           ((occ_after_pop + CW'(inflight)) < CW'(FIFO_DEPTH));

`ifdef IFU_RANGE_CHECK_EN
    logic halted;

    assign fault_now = (fetch_pc[1:0] != 2'b00) || (fetch_pc[31:ADDR_WIDTH+2] != '0);
    assign issue     = req_ok && !halted;

    // A faulting PC still occupies the in-flight slot so its entry keeps normal latency.
    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            halted         <= 1'b0;
            inflight_fault <= 1'b0;
        end else if (issue) begin
            inflight_fault <= fault_now;
            if (fault_now) halted <= 1'b1;
        end
    end

    assign fetch_fault = head_entry.fault;
`else
    logic unused_fault;

    assign fault_now      = 1'b0;
    assign issue          = req_ok;
    assign inflight_fault = 1'b0;
    assign fetch_fault    = 1'b0;
    assign unused_fault   = head_entry.fault;
`endif

    assign csb1  = !(rst_n && issue && !fault_now);
    assign addr1 = fetch_pc[ADDR_WIDTH+1:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    inflight_pc <= fetch_pc;
                    if (!fault_now) fetch_pc <= fetch_pc + 32'd4;
                end
            end
        end
    end

    assign push = inflight && !redirect_valid;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = inflight_pc;
        push_entry.data  = inflight_fault ? NOP_INSTR : 32'(dout1);
        push_entry.fault = inflight_fault;
    end

    ifu_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head_entry),
        .valid     (instr_valid),
        .count     (count)
    );

    assign instr_data = DATA_WIDTH'(head_entry.data);
    assign instr_pc   = head_entry.pc;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit with a registered-read SRAM model.
// Fault-path vectors are compiled in when IFU_RANGE_CHECK_EN is defined.
module tb_imem_fetch_unit;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_en;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [31:0]   instr_pc;
    logic          fetch_fault;

    logic [DW-1:0] mem [512];
    int unsigned   n_vec  = 0;
    int unsigned   n_miss = 0;
    int unsigned   lows;

    always #5 clk = ~clk;

    imem_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(4),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .csb1          (csb1),
        .addr1         (addr1),
        .dout1         (dout1),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .fetch_fault   (fetch_fault)
    );

    // SRAM port 1: address sampled at the edge, data valid the following cycle.
    always @(posedge clk) begin
        if (!csb1) dout1 <= mem[addr1];
    end

    function automatic logic [31:0] exp_data(input logic [31:0] pc);
        return 32'h0000_00A0 + 32'(pc[10:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Land 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_stream(input string tag, input logic [31:0] pc0, input int unsigned n);
        logic [31:0] pc;
        pc = pc0;
        for (int unsigned i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
            chk({tag, "_pc"},    instr_pc, pc);
            chk({tag, "_data"},  instr_data, exp_data(pc));
            chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
            pc = pc + 32'd4;
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0000_00A0 + 32'(i);

        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        #1;
        chk("rst_comb_csb", 32'(csb1), 32'd1);

        // Reset state
        step();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_data",  instr_data, 32'd0);
        chk("rst_pc",    instr_pc, 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_addr",  32'(addr1), 32'd0);
        chk("rst_csb",   32'(csb1), 32'd1);

        // Start-up latency and streaming
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        #1;
        chk("c0_csb", 32'(csb1), 32'd1);
        step();
        chk("c1_csb",  32'(csb1), 32'd0);
        chk("c1_addr", 32'(addr1), 32'd0);
        step();
        chk("c2_addr",  32'(addr1), 32'd1);
        chk("c2_valid", 32'(instr_valid), 32'd0);
        step();
        chk_stream("run", 32'h0, 6);

        // Backpressure: exactly FIFO_DEPTH requests, head held stable
        redirect_valid = 1'b1; redirect_pc = 32'h0; instr_ready = 1'b0;
        #1;
        chk("bp_redir_csb", 32'(csb1), 32'd1);
        step();
        redirect_valid = 1'b0;
        #1;
        lows = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (!csb1) lows++;
            if (i >= 3) chk("bp_hold_pc", instr_pc, 32'h0);
            step();
        end
        chk("bp_req_count", lows, 32'd4);
        chk("bp_valid",     32'(instr_valid), 32'd1);
        chk("bp_data",      instr_data, exp_data(32'h0));
        chk("bp_csb_idle",  32'(csb1), 32'd1);
        instr_ready = 1'b1;
        #1;
        chk("bp_resume_csb",  32'(csb1), 32'd0);
        chk("bp_resume_addr", 32'(addr1), 32'd4);
        chk_stream("drain", 32'h0, 6);

        // Redirect with 3 buffered and 1 in flight, ready high in the same cycle
        redirect_valid = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        step(); step(); step(); step();
        chk("fl_pre_valid", 32'(instr_valid), 32'd1);
        chk("fl_pre_pc",    instr_pc, 32'h200);
        redirect_valid = 1'b1; redirect_pc = 32'h100; instr_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("fl_r1_valid", 32'(instr_valid), 32'd0);
        chk("fl_r1_csb",   32'(csb1), 32'd0);
        chk("fl_r1_addr",  32'(addr1), 32'd64);
        step();
        chk("fl_r2_valid", 32'(instr_valid), 32'd0);
        step();
        chk_stream("fl", 32'h100, 3);

        // Address wrap across 0x7FC -> 0x800
        redirect_valid = 1'b1; redirect_pc = 32'h7F8;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_a0", 32'(addr1), 32'd510);
        step();
        chk("wrap_a1", 32'(addr1), 32'd511);
        step();
        chk("wrap_a2",    32'(addr1), 32'd0);
        chk("wrap_pc0",   instr_pc, 32'h7F8);
        chk("wrap_data0", instr_data, 32'h0000_029E);
`ifdef IFU_RANGE_CHECK_EN
        chk("wrap_fault_csb", 32'(csb1), 32'd1);
`endif
        step();
`ifdef IFU_RANGE_CHECK_EN
        chk("wrap_a3", 32'(addr1), 32'd0);
`else
        chk("wrap_a3", 32'(addr1), 32'd1);
`endif
        chk("wrap_pc1",   instr_pc, 32'h7FC);
        chk("wrap_data1", instr_data, 32'h0000_029F);
        step();
`ifdef IFU_RANGE_CHECK_EN
        chk("wrap_fpc",   instr_pc, 32'h800);
        chk("wrap_fdata", instr_data, 32'h0000_0013);
        chk("wrap_fflag", 32'(fetch_fault), 32'd1);
        step();
`else
        chk("wrap_pc2",   instr_pc, 32'h800);
        chk("wrap_data2", instr_data, 32'h0000_00A0);
        step();
        chk("wrap_pc3",   instr_pc, 32'h804);
        chk("wrap_data3", instr_data, 32'h0000_00A1);
        step();
`endif

        // Reset mid-stream with two entries buffered
        redirect_valid = 1'b1; redirect_pc = 32'h0; instr_ready = 1'b0;
        step();
        redirect_valid = 1'b0;
        step(); step(); step();
        chk("mrst_pre_valid", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_csb",   32'(csb1), 32'd1);
        chk("mrst_addr",  32'(addr1), 32'd0);
        rst_n = 1'b1; instr_ready = 1'b1;
        #1;
        chk("mrst_c0_csb", 32'(csb1), 32'd1);
        step();
        chk("mrst_c1_csb",  32'(csb1), 32'd0);
        chk("mrst_c1_addr", 32'(addr1), 32'd0);
        step();
        step();
        chk_stream("mrst", 32'h0, 3);

`ifdef IFU_RANGE_CHECK_EN
        // Misaligned redirect target faults without touching the SRAM
        redirect_valid = 1'b1; redirect_pc = 32'h802;
        step();
        redirect_valid = 1'b0;
        #1;
        lows = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!csb1) lows++;
            if (i == 2) begin
                chk("flt_valid", 32'(instr_valid), 32'd1);
                chk("flt_pc",    instr_pc, 32'h802);
                chk("flt_data",  instr_data, 32'h0000_0013);
                chk("flt_flag",  32'(fetch_fault), 32'd1);
            end
            step();
        end
        chk("flt_no_access", lows, 32'd0);
        chk("flt_drained",   32'(instr_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("flt_rec_csb", 32'(csb1), 32'd0);
        step();
        step();
        chk_stream("flt_rec", 32'h0, 3);
`endif

        // Dropping fetch_en stops issue one cycle later
        fetch_en = 1'b0;
        step();
        chk("idle_csb", 32'(csb1), 32'd1);
        step();
        chk("idle_csb2", 32'(csb1), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
